// File: rtl/button_conditioner.sv
// button_conditioner: sync + debounce of the three raw buttons,
// drop pulse, and auto-repeating left/right move pulses.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   btn_*_raw         - raw async active-high buttons
//   drop_piece        - one-cycle pulse per accepted drop press
//   move_right/left   - one-cycle pulse on press and on each repeat
//   btn_state         - debounced levels {left, right, drop}
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 10000000,
  parameter int REPEAT_PERIOD   = 3750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_drop_raw,
  input  logic       btn_right_raw,
  input  logic       btn_left_raw,
  output logic       drop_piece,
  output logic       move_right,
  output logic       move_left,
  output logic [2:0] btn_state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD)
                      ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [RW-1:0] DLY_LD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LD = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } mv_state_t;

  // Bit order everywhere: [2]=left, [1]=right, [0]=drop
  logic [2:0]    raw;
  logic [2:0]    s1;
  logic [2:0]    s2;
  logic [2:0]    db;
  logic [2:0]    db_nx;
  logic [2:0]    tgl;
  logic [2:0]    rise;
  logic [DW-1:0] dcnt [3];

  // Move FSMs: index 0 = right, 1 = left
  mv_state_t     st    [2];
  mv_state_t     st_nx [2];
  logic [RW-1:0] rc    [2];
  logic [RW-1:0] rc_nx [2];
  logic [1:0]    fire;
  logic [1:0]    mv_nx;
  logic [1:0]    mv;
  logic          drop_q;

  assign raw = {btn_left_raw, btn_right_raw, btn_drop_raw};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // A toggle is decided this cycle, so pulses can be
  // registered in the same edge that db changes.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      tgl[i]   = (s2[i] != db[i]) && (dcnt[i] == D_LAST);
      db_nx[i] = db[i] ^ tgl[i];
      rise[i]  = tgl[i] & ~db[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db <= '0;
      for (int i = 0; i < 3; i++) begin
        dcnt[i] <= '0;
      end
    end else begin
      db <= db_nx;
      for (int i = 0; i < 3; i++) begin
        if ((s2[i] == db[i]) || tgl[i]) begin
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + D_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= rise[0];
    end
  end

  // Move FSM state register (also holds counters, pulses)
  always_ff @(posedge clk) begin
    if (rst) begin
      mv <= '0;
      for (int j = 0; j < 2; j++) begin
        st[j] <= IDLE;
        rc[j] <= '0;
      end
    end else begin
      mv <= mv_nx;
      for (int j = 0; j < 2; j++) begin
        st[j] <= st_nx[j];
        rc[j] <= rc_nx[j];
      end
    end
  end

  // Move FSM next state; fire marks a scheduled pulse,
  // whether or not it survives the opposite-button gate.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      st_nx[j] = st[j];
      rc_nx[j] = rc[j];
      fire[j]  = 1'b0;
      unique case (st[j])
        IDLE: begin
          if (rise[j+1]) begin
            st_nx[j] = DELAY;
            rc_nx[j] = DLY_LD;
            fire[j]  = 1'b1;
          end
        end
        DELAY, REPEAT: begin
          if (!db_nx[j+1]) begin
            st_nx[j] = IDLE;
          end else if (rc[j] == '0) begin
            st_nx[j] = REPEAT;
            rc_nx[j] = PER_LD;
            fire[j]  = 1'b1;
          end else begin
            rc_nx[j] = rc[j] - R_ONE;
          end
        end
        default: begin
          st_nx[j] = IDLE;
        end
      endcase
    end
  end

  // Move FSM outputs: a pulse is dropped, not deferred,
  // while the opposite direction is held.
  always_comb begin
    mv_nx[0] = fire[0] & ~db_nx[2];
    mv_nx[1] = fire[1] & ~db_nx[1];
  end

  assign drop_piece = drop_q;
  assign move_right = mv[0];
  assign move_left  = mv[1];
  assign btn_state  = db;

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed vectors for
// button_conditioner with DEBOUNCE=4, DELAY=8, PERIOD=3.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] raw;
  logic       drop_piece;
  logic       move_right;
  logic       move_left;
  logic [2:0] btn_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_drop_raw(raw[0]),
    .btn_right_raw(raw[1]),
    .btn_left_raw(raw[2]),
    .drop_piece(drop_piece),
    .move_right(move_right),
    .move_left(move_left),
    .btn_state(btn_state)
  );

  // exp = {btn_state, move_left, move_right, drop_piece}
  typedef struct packed {
    logic       r;
    logic [2:0] in;
    logic [5:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int n, input logic r,
                     input logic [2:0] in,
                     input logic [5:0] e);
    vec_t v;
    v.r = r;
    v.in = in;
    v.exp = e;
    repeat (n) vq.push_back(v);
  endtask

  task automatic step(input logic r, input logic [2:0] in);
    @(negedge clk);
    rst = r;
    raw = in;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] obs();
    return {btn_state, move_left, move_right, drop_piece};
  endfunction

  task automatic chk(input string nm, input logic [5:0] exp);
    logic [5:0] got;
    got = obs();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {st,l,r,d}=%b want %b",
               nm, got, exp);
    end
  endtask

  // One edge with given inputs, then compare
  task automatic run(input string nm, input int e,
                     input logic r, input logic [2:0] in,
                     input logic [2:0] st, input logic l,
                     input logic rt, input logic d);
    step(r, in);
    chk($sformatf("%s e%0d", nm, e), {st, l, rt, d});
  endtask

  logic bnc [7];

  initial begin
    rst = 1'b1;
    raw = 3'b000;

    // Reset with all held, then release: drop pulse only
    add(3,  1'b1, 3'b111, 6'b000_000);
    add(5,  1'b0, 3'b111, 6'b000_000);
    add(1,  1'b0, 3'b111, 6'b111_001);
    add(12, 1'b0, 3'b111, 6'b111_000);
    // Clean drop press of 20 cycles, then release
    add(1,  1'b1, 3'b000, 6'b000_000);
    add(5,  1'b0, 3'b001, 6'b000_000);
    add(1,  1'b0, 3'b001, 6'b001_001);
    add(14, 1'b0, 3'b001, 6'b001_000);
    add(5,  1'b0, 3'b000, 6'b001_000);
    add(7,  1'b0, 3'b000, 6'b000_000);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].r, vq[i].in);
      chk($sformatf("vec%0d", i), vq[i].exp);
    end

    // Bounce on right: 1,1,1,0,1,1,0 then steady 1
    run("bnc_rst", 0, 1'b1, 3'b000, 3'b000, 0, 0, 0);
    bnc = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int e = 1; e <= 7; e++) begin
      run("bnc", e, 1'b0, {1'b0, bnc[e-1], 1'b0},
          3'b000, 0, 0, 0);
    end
    for (int e = 8; e <= 16; e++) begin
      run("bnc", e, 1'b0, 3'b010,
          (e >= 13) ? 3'b010 : 3'b000, 0, e == 13, 0);
    end

    // Left held 40 cycles: pulses 6, 14, 17, ... 44
    run("rep_rst", 0, 1'b1, 3'b000, 3'b000, 0, 0, 0);
    for (int e = 1; e <= 55; e++) begin
      run("rep", e, 1'b0, (e <= 40) ? 3'b100 : 3'b000,
          (e >= 6 && e <= 45) ? 3'b100 : 3'b000,
          (e == 6) || (e >= 14 && e <= 44 &&
                       (e - 14) % 3 == 0),
          0, 0);
    end
    // FSM back in IDLE: a new press gives a fresh pulse
    for (int e = 1; e <= 8; e++) begin
      run("repress", e, 1'b0, 3'b100,
          (e >= 6) ? 3'b100 : 3'b000, e == 6, 0, 0);
    end

    // All three rise together; then right released at 20
    run("sim_rst", 0, 1'b1, 3'b000, 3'b000, 0, 0, 0);
    for (int e = 1; e <= 33; e++) begin
      run("sim", e, 1'b0, (e < 20) ? 3'b111 : 3'b101,
          (e < 6) ? 3'b000 : ((e < 25) ? 3'b111 : 3'b101),
          (e >= 26) && ((e - 14) % 3 == 0),
          0, e == 6);
    end

    // Right in REPEAT, reset on a due pulse edge
    run("mid_rst", 0, 1'b1, 3'b000, 3'b000, 0, 0, 0);
    for (int e = 1; e <= 19; e++) begin
      run("mid", e, 1'b0, 3'b010,
          (e >= 6) ? 3'b010 : 3'b000, 0,
          (e == 6) || (e == 14) || (e == 17), 0);
    end
    run("mid", 20, 1'b1, 3'b010, 3'b000, 0, 0, 0);
    for (int e = 21; e <= 41; e++) begin
      run("mid", e, 1'b0, 3'b010,
          (e >= 26) ? 3'b010 : 3'b000, 0,
          (e == 26) || (e == 34) || (e == 37) || (e == 40),
          0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
